ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  PS/2 device-to-host receiver. Filters and synchronises ps2_clk/ps2_data and decodes 11-bit frames:
//   start, 8 data LSB-first, odd parity, stop.
//  Checks parity, stop bit and inter-bit timeout. Buffers good bytes in a FIFO with a valid/ready output.
//  Sits between the PS/2 pins and the keyboard scancode decoder; replaces the unbuffered receiver.
// PARAMETERS
//  FILTER_LEN  8       ps2_clk glitch-filter length in clk cycles (>=2)
//  TIMEOUT     100000  clk cycles allowed between bit edges inside a frame (>=16)
//  DEPTH       8       FIFO entries, power of 2 (>=2)
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous, active-low reset
//  ps2_clk      in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data     in   1  raw PS/2 data pin (asynchronous)
//  out_data     out  8  head-of-FIFO byte, valid only while out_valid=1
//  out_valid    out  1  FIFO non-empty
//  out_ready    in   1  consumer accepts; pop on out_valid & out_ready
//  busy         out  1  frame in progress (FSM != IDLE)
//  err_parity   out  1  1-cycle pulse: parity bad, byte dropped
//  err_frame    out  1  1-cycle pulse: stop bit 0 or timeout, frame dropped
//  err_overflow out  1  1-cycle pulse: good byte arrived with FIFO full, byte dropped
// BEHAVIOUR
//  - Reset: outputs 0, FSM IDLE, FIFO empty, timeout counter 0; synchronisers and filter preset to 1 (idle line).
//  - ps2_clk and ps2_data each pass a 2-FF synchroniser. Synced clk feeds a FILTER_LEN shift register.
//    Filtered level goes 0 when all taps are 0 and 1 when all taps are 1; otherwise it holds.
//  - strobe = 1-cycle pulse on a 1->0 transition of the filtered level; bit = synced ps2_data in that cycle.
//  - FSM, advancing only on strobe:
//    IDLE: bit=0 -> DATA, cnt=0; bit=1 -> stay in IDLE, ignored.
//    DATA: shift bit into sr[7] (LSB-first); after the 8th bit -> PARITY.
//    PARITY: store p -> STOP.
//    STOP: if bit=0 -> err_frame. Else if ^{sr,p}=0 -> err_parity.
//      Else push if not full, otherwise err_overflow. Always -> IDLE.
//  - Timeout: counter clears on every strobe and in IDLE, increments otherwise.
//    At TIMEOUT-1 with no strobe -> err_frame, FSM -> IDLE, partial byte discarded.
//    A strobe in the same cycle as the timeout has priority.
//  - Latency: push at the end of the STOP-strobe cycle; out_valid=1 the next cycle if the FIFO was empty.
//    Strobe lags the pin edge by 2 + FILTER_LEN cycles.
//  - FIFO: ptrs $clog2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & rest equal.
//    out_data = mem[rd_ptr] (combinational). Push while full is rejected unless a pop happens in the same cycle;
//    simultaneous push+pop both proceed.
//    out_ready with out_valid=0 is a no-op. out_data and out_valid stay stable until popped.
//  - At most one err_* pulse per frame. Errors never block later frames.
//  - Reset asserted mid-frame: frame and FIFO contents lost; after release, first valid start bit begins a new frame.
// STRUCTURE
//  - Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), PS2_FRAME_BITS=11, odd-parity function.
//  - Sub-module sync_fifo (WIDTH, DEPTH): generic push/pop FIFO with full/empty, reused by the keyboard TX path.
//  - Synchroniser, filter, FSM and timeout stay in this module.
// TESTING (clk 50 MHz, ps2 bit period 80 us unless stated)
//  1. Frame 0x1C (start0, 0,0,1,1,1,0,0,0, parity 0, stop1), out_ready=1
//     -> out_valid 1 cycle, out_data=0x1C, no err_*, busy low after stop.
//  2. Same frame with parity=1 -> err_parity single pulse, out_valid stays 0; following 0xF0 frame delivered intact.
//  3. 2-cycle low glitch on ps2_clk in IDLE and mid-DATA (FILTER_LEN=8) -> no strobe, no state change; byte still correct.
//  4. Stop toggling after 5 data bits for TIMEOUT cycles -> err_frame pulse, busy=0; next 0xAA frame received.
//  5. DEPTH=4, out_ready=0, send 0x11,0x22,0x33,0x44,0x55 -> 5th gives err_overflow;
//     drain yields 0x11..0x44 in order, then out_valid=0.
//  6. Assert reset_n=0 after 4 data bits, release, send 0x5A -> only 0x5A appears, no err_*.
//     Stop bit 0 on a frame -> err_frame only.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, receiver state encoding and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    // Parity bit that makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic single-clock push/pop FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO may proceed.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame checks and output FIFO
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000,
    parameter int DEPTH      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_filt;
    logic                  w_filt;
    logic                  w_strobe;
    logic                  w_bit;

    ps2_state_t            r_state;
    ps2_state_t            w_state_nxt;
    logic [2:0]            r_bit_cnt;
    logic [2:0]            w_bit_cnt_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic                  r_par;
    logic                  w_par_nxt;
    logic [TW-1:0]         r_to_cnt;
    logic [TW-1:0]         w_to_cnt_nxt;
    logic                  w_timeout;

    logic                  r_err_parity;
    logic                  r_err_frame;
    logic                  r_err_overflow;
    logic                  w_err_parity;
    logic                  w_err_frame;
    logic                  w_err_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    // Synchronisers and filter start at 1 so a released reset looks like an idle line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt_sr   <= '1;
            r_filt      <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_filt_sr   <= {r_filt_sr[FILTER_LEN-2:0], r_clk_sync[1]};
            r_filt      <= w_filt;
        end
    end

    always_comb begin
        w_filt = r_filt;
        if (&r_filt_sr) begin
            w_filt = 1'b1;
        end else if (~|r_filt_sr) begin
            w_filt = 1'b0;
        end
    end

    assign w_strobe = r_filt & ~w_filt;
    assign w_bit    = r_data_sync[1];
    assign w_pop    = out_ready & ~w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_par          <= 1'b0;
            r_to_cnt       <= '0;
            r_err_parity   <= 1'b0;
            r_err_frame    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_shift        <= w_shift_nxt;
            r_par          <= w_par_nxt;
            r_to_cnt       <= w_to_cnt_nxt;
            r_err_parity   <= w_err_parity;
            r_err_frame    <= w_err_frame;
            r_err_overflow <= w_err_overflow;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_push         = 1'b0;
        w_err_parity   = 1'b0;
        w_err_frame    = 1'b0;
        w_err_overflow = 1'b0;

        // A strobe landing on the last allowed cycle still counts as a valid bit.
        w_timeout = (r_state != IDLE) && !w_strobe && (r_to_cnt == TW'(TIMEOUT - 1));

        if ((r_state == IDLE) || w_strobe || w_timeout) begin
            w_to_cnt_nxt = '0;
        end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_strobe && !w_bit) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (w_strobe) begin
                    w_shift_nxt   = {w_bit, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (w_strobe) begin
                    w_par_nxt   = w_bit;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_strobe) begin
                    w_state_nxt = IDLE;
                    if (!w_bit) begin
                        w_err_frame = 1'b1;
                    end else if (odd_parity(r_shift) != r_par) begin
                        w_err_parity = 1'b1;
                    end else if (w_full && !w_pop) begin
                        w_err_overflow = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_frame = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (out_ready),
        .o_pop_data  (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign out_valid    = ~w_empty;
    assign busy         = (r_state != IDLE);
    assign err_parity   = r_err_parity;
    assign err_frame    = r_err_frame;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo with directed PS/2 frames
module tb_ps2_rx_fifo;

    localparam int FL = 8;
    localparam int TO = 200;
    localparam int DP = 4;
    localparam int H  = 20;

    localparam int E_PAR = 1;
    localparam int E_FRM = 2;
    localparam int E_OVF = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       err_parity;
    logic       err_frame;
    logic       err_overflow;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_data[$];
    int         exp_err[$];
    logic [7:0] m_exp_byte;
    int         m_exp_err;

    ps2_rx_fifo #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO),
        .DEPTH      (DP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overflow (err_overflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit i of fr goes out on the i-th falling edge; optional 2-cycle low glitch in the preceding high phase.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_at) begin
                cyc(H / 2);
                ps2_clk = 1'b0;
                cyc(2);
                ps2_clk = 1'b1;
                cyc(H / 2 - 2);
            end else begin
                cyc(H);
            end
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int glitch_at);
        send_bits({stop, p, d, 1'b0}, 11, glitch_at);
        ps2_data = 1'b1;
        cyc(40);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rx_byte: got %02h expected no byte", out_data);
                end else begin
                    m_exp_byte = exp_data.pop_front();
                    check("rx_byte", {24'd0, out_data}, {24'd0, m_exp_byte});
                end
            end
            if (err_parity || err_frame || err_overflow) begin
                if (exp_err.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL err_pulse: got code %0d expected no error",
                             {err_overflow, err_frame, err_parity});
                end else begin
                    m_exp_err = exp_err.pop_front();
                    check("err_pulse", {29'd0, err_overflow, err_frame, err_parity}, m_exp_err);
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cyc(5);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_parity", err_parity, 0);
        check("rst_err_frame", err_frame, 0);
        check("rst_err_overflow", err_overflow, 0);
        reset_n = 1'b1;
        cyc(10);

        // 0x1C: three ones, odd parity bit 0
        exp_data.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check("t1_busy_after_stop", busy, 0);
        check("t1_valid_drained", out_valid, 0);

        exp_err.push_back(E_PAR);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        check("t2_no_valid", out_valid, 0);
        exp_data.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1, -1);

        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(30);
        check("t3_idle_glitch_busy", busy, 0);
        exp_data.push_back(8'h35);
        send_frame(8'h35, 1'b1, 1'b1, 4);

        // start + 5 data bits, then silence
        exp_err.push_back(E_FRM);
        send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 6, -1);
        ps2_data = 1'b1;
        check("t4_busy_mid_frame", busy, 1);
        cyc(TO + 40);
        check("t4_busy_after_timeout", busy, 0);
        check("t4_err_consumed", exp_err.size(), 0);
        exp_data.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, 1'b1, -1);

        out_ready = 1'b0;
        exp_data.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1, -1);
        exp_data.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        exp_data.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b1, -1);
        exp_data.push_back(8'h44);
        send_frame(8'h44, 1'b1, 1'b1, -1);
        exp_err.push_back(E_OVF);
        send_frame(8'h55, 1'b1, 1'b1, -1);
        check("t5_valid_while_full", out_valid, 1);
        check("t5_head_stable", out_data, 8'h11);
        out_ready = 1'b1;
        cyc(10);
        check("t5_drained", exp_data.size(), 0);
        check("t5_valid_after_drain", out_valid, 0);

        send_bits({1'b1, 1'b1, 8'hC3, 1'b0}, 5, -1);
        reset_n = 1'b0;
        cyc(3);
        check("t6_busy_in_reset", busy, 0);
        check("t6_valid_in_reset", out_valid, 0);
        reset_n = 1'b1;
        cyc(20);
        exp_data.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        exp_err.push_back(E_FRM);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        cyc(20);
        check("end_bytes_consumed", exp_data.size(), 0);
        check("end_errs_consumed", exp_err.size(), 0);
        check("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
